// File: rtl/data_pipe_interconnect_sm_m0_pkg.sv
// Shared types and sizes for the 8-to-1 data-pipe merge interconnect.
package data_pipe_interconnect_pkg;

  localparam int NUM_PORTS = 8;
  localparam int PATH_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMPTY = 2'd1,
    ONE   = 2'd2,
    TWO   = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/data_pipe_interconnect_sm_m0_if.sv
// Valid/ready/data stream interface used on every port of the interconnect.
interface data_inf #(
  parameter int DSIZE = 8
);
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/data_pipe_interconnect_sm_m0_skid2.sv
// Two-entry skid stage: connector drives the output, buffer catches the one
// word accepted while the output stalls. Upstream ready is registered.
module data_pipe_skid2
  import data_pipe_interconnect_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  input  logic             out_ready,
  output logic             up_hs,
  output logic             empty_next,
  output logic             pipe_empty
);

  pipe_state_e      state_q, state_d;
  logic [DSIZE-1:0] connector_q, connector_d;
  logic [DSIZE-1:0] buffer_q, buffer_d;
  logic             connector_vld_q, connector_vld_d;
  logic             to_up_ready_q, to_up_ready_d;
  logic             dn_hs;

  assign up_hs      = in_valid & to_up_ready_q & clk_en;
  assign dn_hs      = connector_vld_q & out_ready & clk_en;
  assign in_ready   = to_up_ready_q;
  assign out_valid  = connector_vld_q;
  assign out_data   = connector_q;
  assign empty_next = (state_d == EMPTY);
  assign pipe_empty = (state_q == IDLE) || (state_q == EMPTY);

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      connector_q     <= '0;
      buffer_q        <= '0;
      connector_vld_q <= 1'b0;
      to_up_ready_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      connector_q     <= connector_d;
      buffer_q        <= buffer_d;
      connector_vld_q <= connector_vld_d;
      to_up_ready_q   <= to_up_ready_d;
    end
  end

  // Occupancy tracking: count words held, moving only when clk_en is high.
  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      case (state_q)
        IDLE:  state_d = EMPTY;
        EMPTY: if (up_hs) state_d = ONE;
        ONE: begin
          if (up_hs && !dn_hs)      state_d = TWO;
          else if (!up_hs && dn_hs) state_d = EMPTY;
        end
        TWO:   if (dn_hs) state_d = ONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Word movement between input, connector and buffer, plus the ready register.
  always_comb begin
    connector_d     = connector_q;
    buffer_d        = buffer_q;
    connector_vld_d = connector_vld_q;
    to_up_ready_d   = to_up_ready_q;
    if (clk_en) begin
      case (state_q)
        EMPTY: if (up_hs) connector_d = in_data;
        ONE: begin
          if (up_hs && dn_hs) connector_d = in_data;
          else if (up_hs)     buffer_d    = in_data;
        end
        TWO: begin
          if (dn_hs) begin
            connector_d = buffer_q;
            buffer_d    = '0;
          end
        end
        default: ;
      endcase
      connector_vld_d = (state_d == ONE) || (state_d == TWO);
      to_up_ready_d   = (state_d != TWO);
    end
  end

endmodule

// File: rtl/data_pipe_interconnect_sm_m0.sv
// 8-to-1 data-pipe merge: selects one upstream port into a shared skid stage.
// The selected path only changes while the skid holds no words.
module data_pipe_interconnect_sm_m0
  import data_pipe_interconnect_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              vld_sw,
  input  logic [PATH_W-1:0] sw,
  output logic [PATH_W-1:0] curr_path,
  output logic              pipe_empty,
  data_inf.slaver           s00,
  data_inf.slaver           s01,
  data_inf.slaver           s02,
  data_inf.slaver           s03,
  data_inf.slaver           s04,
  data_inf.slaver           s05,
  data_inf.slaver           s06,
  data_inf.slaver           s07,
  data_inf.master           m00
);

  logic [NUM_PORTS-1:0] up_valid_vec;
  logic [NUM_PORTS-1:0] up_ready_vec;
  logic [DSIZE-1:0]     up_data_vec [NUM_PORTS];
  logic [PATH_W-1:0]    curr_path_q, curr_path_d;
  logic                 curr_path_vld_q, curr_path_vld_d;
  logic                 sel_valid;
  logic [DSIZE-1:0]     sel_data;
  logic                 to_up_ready;
  logic                 up_hs;
  logic                 empty_next;
  logic                 switch_en;

  assign up_valid_vec = {s07.valid, s06.valid, s05.valid, s04.valid,
                         s03.valid, s02.valid, s01.valid, s00.valid};
  assign up_data_vec[0] = s00.data;
  assign up_data_vec[1] = s01.data;
  assign up_data_vec[2] = s02.data;
  assign up_data_vec[3] = s03.data;
  assign up_data_vec[4] = s04.data;
  assign up_data_vec[5] = s05.data;
  assign up_data_vec[6] = s06.data;
  assign up_data_vec[7] = s07.data;
  assign s00.ready = up_ready_vec[0];
  assign s01.ready = up_ready_vec[1];
  assign s02.ready = up_ready_vec[2];
  assign s03.ready = up_ready_vec[3];
  assign s04.ready = up_ready_vec[4];
  assign s05.ready = up_ready_vec[5];
  assign s06.ready = up_ready_vec[6];
  assign s07.ready = up_ready_vec[7];

  assign sel_valid = up_valid_vec[curr_path_q] & curr_path_vld_q;
  assign sel_data  = up_data_vec[curr_path_q];
  assign curr_path = curr_path_q;
  assign switch_en = clk_en & vld_sw & empty_next & ~up_hs;

  // Only the active path ever sees ready; every other port stays stalled.
  always_comb begin
    up_ready_vec              = '0;
    up_ready_vec[curr_path_q] = to_up_ready & curr_path_vld_q;
  end

  // Path switch takes effect only when the pipe will be empty after this cycle.
  always_comb begin
    curr_path_d     = curr_path_q;
    curr_path_vld_d = curr_path_vld_q;
    if (switch_en) begin
      curr_path_d     = sw;
      curr_path_vld_d = 1'b1;
    end
  end

  // Path selection registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      curr_path_q     <= '0;
      curr_path_vld_q <= 1'b0;
    end else begin
      curr_path_q     <= curr_path_d;
      curr_path_vld_q <= curr_path_vld_d;
    end
  end

  data_pipe_skid2 #(.DSIZE(DSIZE)) u_skid (
    .clk        (clock),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .in_valid   (sel_valid),
    .in_data    (sel_data),
    .in_ready   (to_up_ready),
    .out_valid  (m00.valid),
    .out_data   (m00.data),
    .out_ready  (m00.ready),
    .up_hs      (up_hs),
    .empty_next (empty_next),
    .pipe_empty (pipe_empty)
  );

endmodule
